// File: rtl/tlc_pkg.sv
// Shared lamp encodings, fault causes and monitor states for the traffic-light safety path.
package tlc_pkg;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_ENCODING = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_SEQUENCE = 3'd3,
        FC_DWELL    = 3'd4
    } fault_code_t;

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_PASS,
        ST_FAULT
    } mon_state_t;

    function automatic logic is_lamp(input logic [2:0] code);
        return (code == LAMP_GREEN) || (code == LAMP_YELLOW) || (code == LAMP_RED);
    endfunction

    function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
        return ((from == LAMP_GREEN)  && (to == LAMP_YELLOW)) ||
               ((from == LAMP_YELLOW) && (to == LAMP_RED))    ||
               ((from == LAMP_RED)    && (to == LAMP_GREEN));
    endfunction

endpackage

// File: rtl/tlc_flash_timer.sv
// Half-period down-counter and phase flop for the fault-mode lamp flash.
module tlc_flash_timer #(
    parameter int FLASH_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic phase,
    output logic phase_nxt
);

    localparam int CW = $clog2(FLASH_HALF) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(FLASH_HALF - 1);

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc = enable && !restart && (cnt == '0);

    // Lets the owner register its lamps in step with the phase flop.
    assign phase_nxt = restart ? 1'b1 : (phase ^ tc);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= RELOAD;
            phase <= 1'b1;
        end else if (restart) begin
            cnt   <= RELOAD;
            phase <= 1'b1;
        end else if (enable) begin
            if (tc) begin
                cnt   <= RELOAD;
                phase <= ~phase;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_lamp_monitor.sv
// Lamp safety monitor: registers sequencer lamp codes, latches the first violation and forces red.
// Build option TLC_LAMP_MON_FLASH_EN: fault-mode red flashes instead of holding steady.
module tlc_lamp_monitor
    import tlc_pkg::*;
#(
    parameter int STARTUP_CYC = 4,
    parameter int MIN_GREEN   = 3,
    parameter int MIN_YELLOW  = 3,
    parameter int FLASH_HALF  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ns_in,
    input  logic [2:0] ew_in,
    input  logic       fault_clr,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    // state   | meaning
    // STARTUP | forced all-red for STARTUP_CYC cycles, checks active
    // PASS    | inputs registered to lamps, checks active
    // FAULT   | cause latched, lamps fail-safe red, waits for an accepted clear

    localparam int DWELL_MAX = (MIN_GREEN > MIN_YELLOW) ? MIN_GREEN : MIN_YELLOW;
    localparam int DW        = $clog2(DWELL_MAX) + 1;
    localparam int SW        = $clog2(STARTUP_CYC) + 1;

    localparam logic [DW-1:0] DWELL_SAT = DW'(DWELL_MAX);
    localparam logic [DW-1:0] MIN_G_W   = DW'(MIN_GREEN);
    localparam logic [DW-1:0] MIN_Y_W   = DW'(MIN_YELLOW);
    localparam logic [SW-1:0] START_TC  = SW'(STARTUP_CYC - 1);

    mon_state_t    state;
    fault_code_t   code_q;
    fault_code_t   chk_code;
    logic [2:0]    prev_ns;
    logic [2:0]    prev_ew;
    logic [DW-1:0] dwell;
    logic [SW-1:0] start_cnt;

    logic bad_enc, conflict, bad_seq, short_dwell;
    logic ns_chg, ew_chg, pair_chg, chk_fire;
    logic flash_on;

    always_comb begin
        bad_enc     = !is_lamp(ns_in) || !is_lamp(ew_in);
        conflict    = (ns_in != LAMP_RED) && (ew_in != LAMP_RED);
        ns_chg      = (ns_in != prev_ns);
        ew_chg      = (ew_in != prev_ew);
        pair_chg    = ns_chg || ew_chg;
        bad_seq     = (ns_chg && !legal_step(prev_ns, ns_in)) ||
                      (ew_chg && !legal_step(prev_ew, ew_in));
        short_dwell = (ns_chg && (((prev_ns == LAMP_GREEN)  && (dwell < MIN_G_W)) ||
                                  ((prev_ns == LAMP_YELLOW) && (dwell < MIN_Y_W)))) ||
                      (ew_chg && (((prev_ew == LAMP_GREEN)  && (dwell < MIN_G_W)) ||
                                  ((prev_ew == LAMP_YELLOW) && (dwell < MIN_Y_W))));
        chk_code = FC_NONE;
        if (bad_enc)          chk_code = FC_ENCODING;
        else if (conflict)    chk_code = FC_CONFLICT;
        else if (bad_seq)     chk_code = FC_SEQUENCE;
        else if (short_dwell) chk_code = FC_DWELL;
        chk_fire = (chk_code != FC_NONE);
    end

`ifdef TLC_LAMP_MON_FLASH_EN
    logic flash_phase;

    tlc_flash_timer #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flash (
        .clk       (clk),
        .rst       (rst),
        .enable    (state == ST_FAULT),
        .restart   (chk_fire && (state != ST_FAULT)),
        .phase     (flash_phase),
        .phase_nxt (flash_on)
    );
`else
    assign flash_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STARTUP;
            ns_lamp   <= LAMP_RED;
            ew_lamp   <= LAMP_RED;
            fault     <= 1'b0;
            code_q    <= FC_NONE;
            prev_ns   <= LAMP_RED;
            prev_ew   <= LAMP_RED;
            dwell     <= '0;
            start_cnt <= '0;
        end else begin
            case (state)
                ST_STARTUP, ST_PASS: begin
                    prev_ns <= ns_in;
                    prev_ew <= ew_in;
                    if (pair_chg)                dwell <= DW'(1);
                    else if (dwell != DWELL_SAT) dwell <= dwell + 1'b1;

                    if (chk_fire) begin
                        state   <= ST_FAULT;
                        fault   <= 1'b1;
                        code_q  <= chk_code;
                        ns_lamp <= LAMP_RED;
                        ew_lamp <= LAMP_RED;
                    end else if (state == ST_STARTUP) begin
                        ns_lamp <= LAMP_RED;
                        ew_lamp <= LAMP_RED;
                        if (start_cnt == START_TC) state <= ST_PASS;
                        else                       start_cnt <= start_cnt + 1'b1;
                    end else begin
                        ns_lamp <= ns_in;
                        ew_lamp <= ew_in;
                    end
                end

                ST_FAULT: begin
                    // Clear is only honoured once the sequencer offers a sane, non-conflicting pair.
                    if (fault_clr && !bad_enc && !conflict) begin
                        state     <= ST_STARTUP;
                        fault     <= 1'b0;
                        code_q    <= FC_NONE;
                        prev_ns   <= ns_in;
                        prev_ew   <= ew_in;
                        dwell     <= DW'(1);
                        start_cnt <= '0;
                        ns_lamp   <= LAMP_RED;
                        ew_lamp   <= LAMP_RED;
                    end else begin
                        ns_lamp <= flash_on ? LAMP_RED : LAMP_OFF;
                        ew_lamp <= flash_on ? LAMP_RED : LAMP_OFF;
                    end
                end

                default: state <= ST_STARTUP;
            endcase
        end
    end

    assign fault_code = code_q;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Directed scoreboard bench for tlc_lamp_monitor; expects flashing red only when TLC_LAMP_MON_FLASH_EN is defined.
module tb_tlc_lamp_monitor;

    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] OFF = 3'b000;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ns_in, ew_in;
    logic       fault_clr;
    logic [2:0] ns_lamp, ew_lamp;
    logic       fault;
    logic [2:0] fault_code;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       f;
        logic [2:0] code;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   fk = 0;

    tlc_lamp_monitor #(
        .STARTUP_CYC (4),
        .MIN_GREEN   (3),
        .MIN_YELLOW  (3),
        .FLASH_HALF  (HALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ns_in      (ns_in),
        .ew_in      (ew_in),
        .fault_clr  (fault_clr),
        .ns_lamp    (ns_lamp),
        .ew_lamp    (ew_lamp),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] flash_lamp(input int k);
`ifdef TLC_LAMP_MON_FLASH_EN
        return (((k / HALF) % 2) == 0) ? R : OFF;
`else
        return R;
`endif
    endfunction

    task automatic check_out();
        exp_t x;
        logic [9:0] obs, want;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed no entry, expected one");
            return;
        end
        x = sbq.pop_front();
        obs  = {ns_lamp, ew_lamp, fault, fault_code};
        want = {x.ns, x.ew, x.f, x.code};
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed ns=%b ew=%b fault=%b code=%0d, expected ns=%b ew=%b fault=%b code=%0d",
                   x.tag, ns_lamp, ew_lamp, fault, fault_code, x.ns, x.ew, x.f, x.code);
        end
    endtask

    task automatic cyc(input logic [2:0] n, input logic [2:0] e, input logic c,
                       input logic [2:0] xn, input logic [2:0] xe, input logic xf,
                       input logic [2:0] xc, input string tag);
        exp_t x;
        ns_in = n; ew_in = e; fault_clr = c;
        x.ns = xn; x.ew = xe; x.f = xf; x.code = xc; x.tag = tag;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic fcyc(input logic [2:0] n, input logic [2:0] e, input logic c,
                        input logic [2:0] xc, input string tag);
        cyc(n, e, c, flash_lamp(fk), flash_lamp(fk), 1'b1, xc, tag);
        fk++;
    endtask

    task automatic pass(input logic [2:0] n, input logic [2:0] e, input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) cyc(n, e, 1'b0, n, e, 1'b0, 3'd0, tag);
    endtask

    task automatic startup_run(input logic [2:0] n, input logic [2:0] e, input int npass);
        for (int i = 0; i < 4; i++) cyc(n, e, 1'b0, R, R, 1'b0, 3'd0, "startup_red");
        pass(n, e, npass, "startup_pass");
    endtask

    initial begin
        logic [2:0] seq_ns [4];
        logic [2:0] seq_ew [4];
        int e;
        seq_ns = '{G, Y, R, R};
        seq_ew = '{R, R, G, Y};

        rst = 1'b1; ns_in = R; ew_in = R; fault_clr = 1'b0;
        cyc(R, R, 1'b0, R, R, 1'b0, 3'd0, "reset");
        cyc(R, R, 1'b0, R, R, 1'b0, 3'd0, "reset");
        rst = 1'b0;

        // Three full sequencer rounds, 6 cycles per phase, first 4 edges forced red.
        e = 0;
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < 4; s++)
                for (int k = 0; k < 6; k++) begin
                    e++;
                    if (e <= 4) cyc(seq_ns[s], seq_ew[s], 1'b0, R, R, 1'b0, 3'd0, "normal_startup");
                    else        cyc(seq_ns[s], seq_ew[s], 1'b0, seq_ns[s], seq_ew[s], 1'b0, 3'd0, "normal_pass");
                end

        cyc(3'b011, Y, 1'b0, R, R, 1'b1, 3'd1, "enc_detect");
        fk = 1;
        repeat (11) fcyc(R, Y, 1'b0, 3'd1, "enc_flash_hold");
        repeat (2)  fcyc(G, G, 1'b1, 3'd1, "clr_rejected");
        cyc(G, R, 1'b1, R, R, 1'b0, 3'd0, "clr_accept");
        startup_run(G, R, 2);

        pass(Y, R, 3, "pass_yr");
        pass(R, R, 2, "pass_rr");
        pass(G, R, 3, "green3");
        pass(Y, R, 3, "green3_accepted");
        pass(R, R, 1, "pass_rr2");
        pass(G, R, 2, "green2");
        cyc(Y, R, 1'b0, R, R, 1'b1, 3'd4, "dwell_detect");
        fk = 1;
        repeat (3) fcyc(Y, R, 1'b0, 3'd4, "dwell_hold");

        cyc(R, R, 1'b1, R, R, 1'b0, 3'd0, "clr2");
        startup_run(R, R, 1);
        pass(G, R, 5, "green5");
        cyc(R, R, 1'b0, R, R, 1'b1, 3'd3, "seq_detect");
        fk = 1;
        repeat (2) fcyc(R, R, 1'b0, 3'd3, "seq_hold");

        cyc(R, R, 1'b1, R, R, 1'b0, 3'd0, "clr3");
        startup_run(R, R, 1);
        cyc(G, G, 1'b0, R, R, 1'b1, 3'd2, "conflict_detect");
        fk = 1;
        repeat (2) fcyc(R, R, 1'b0, 3'd2, "conflict_hold");

        cyc(R, R, 1'b1, R, R, 1'b0, 3'd0, "clr4");
        startup_run(R, R, 1);
        cyc(3'b110, Y, 1'b0, R, R, 1'b1, 3'd1, "priority_detect");
        fk = 1;
        repeat (5) fcyc(R, R, 1'b0, 3'd1, "priority_flash");

        // Edge count since detection is now in the dark half of the flash.
        rst = 1'b1;
        cyc(R, R, 1'b0, R, R, 1'b0, 3'd0, "rst_midflash");
        rst = 1'b0;
        startup_run(G, R, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
